// File: rtl/dmem_pkg.sv
// dmem_pkg: opcode/funct3 constants and FSM state type for the data-memory stage.
`default_nettype none

package dmem_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        RESP   = 2'd3
    } dmem_state_t;

endpackage

`default_nettype wire

// File: rtl/dmem_lane_align.sv
// dmem_lane_align: byte-lane steering for stores, load extraction/extension,
// and misalignment / illegal-funct3 detection.
`default_nettype none

module dmem_lane_align
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_is_store,
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_addr_lo,
    input  logic [XLEN-1:0] i_rs2,
    input  logic [XLEN-1:0] i_rdata,
    output logic [3:0]      o_be,
    output logic [XLEN-1:0] o_wdata,
    output logic [XLEN-1:0] o_load_value,
    output logic            o_misaligned,
    output logic            o_illegal
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];

    always_comb begin
        o_be         = 4'hF;
        o_wdata      = i_rs2;
        o_misaligned = 1'b0;
        case (i_funct3[1:0])
            2'b00: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_rs2[7:0]}};
            end
            2'b01: begin
                o_be         = 4'b0011 << i_addr_lo;
                o_wdata      = {2{i_rs2[15:0]}};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_be         = 4'hF;
                o_wdata      = i_rs2;
                o_misaligned = |i_addr_lo;
            end
        endcase
    end

    always_comb begin
        if (i_is_store) begin
            o_illegal = (i_funct3 >= 3'd3);
        end else begin
            o_illegal = (i_funct3 == 3'd3) || (i_funct3 == 3'd6) || (i_funct3 == 3'd7);
        end
    end

    always_comb begin
        o_load_value = '0;
        case (i_funct3)
            LB:      o_load_value = {{(XLEN-8){w_byte[7]}}, w_byte};
            LH:      o_load_value = {{(XLEN-16){w_half[15]}}, w_half};
            LW:      o_load_value = i_rdata;
            LBU:     o_load_value = {{(XLEN-8){1'b0}}, w_byte};
            LHU:     o_load_value = {{(XLEN-16){1'b0}}, w_half};
            default: o_load_value = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/dmem_stage.sv
// dmem_stage: RV32I data-memory stage; one load/store in flight, bus
// request/grant/response, load alignment and a single writeback beat.
`default_nettype none

module dmem_stage
    import dmem_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [6:0]      in_opcode,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_value,
    input  logic [XLEN-1:0] in_rs2_value,
    input  logic [11:0]     in_imm,
    input  logic [4:0]      in_rd,
    input  logic [XLEN-1:0] in_pc,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [3:0]      mem_be,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            wb_valid,
    input  logic            wb_ready,
    output logic            wb_we,
    output logic [4:0]      wb_rd,
    output logic [XLEN-1:0] wb_rd_value,
    output logic [XLEN-1:0] wb_next_pc,
    output logic            wb_fault
);

    dmem_state_t     r_state;
    dmem_state_t     w_state_nxt;

    logic            r_is_store;
    logic            r_fault;
    logic [2:0]      r_funct3;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_rs2;
    logic [XLEN-1:0] r_next_pc;
    logic [XLEN-1:0] r_rd_value;

    logic            w_idle;
    logic            w_accept;
    logic [XLEN-1:0] w_ea;
    logic            w_al_store;
    logic [2:0]      w_al_funct3;
    logic [1:0]      w_al_addr_lo;
    logic [XLEN-1:0] w_al_rs2;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wdata;
    logic [XLEN-1:0] w_load_value;
    logic            w_misaligned;
    logic            w_illegal;
    logic            w_fault;

    assign w_idle   = (r_state == IDLE);
    assign w_accept = w_idle && in_valid;
    assign w_ea     = in_rs1_value + {{(XLEN-12){in_imm[11]}}, in_imm};

    // One aligner serves both the accept-time fault check (live inputs) and
    // the later bus/load phases (latched operands).
    assign w_al_store   = w_idle ? (in_opcode == OPC_STORE) : r_is_store;
    assign w_al_funct3  = w_idle ? in_funct3    : r_funct3;
    assign w_al_addr_lo = w_idle ? w_ea[1:0]    : r_addr[1:0];
    assign w_al_rs2     = w_idle ? in_rs2_value : r_rs2;
    assign w_fault      = w_misaligned | w_illegal;

    dmem_lane_align #(
        .XLEN (XLEN)
    ) u_align (
        .i_is_store   (w_al_store),
        .i_funct3     (w_al_funct3),
        .i_addr_lo    (w_al_addr_lo),
        .i_rs2        (w_al_rs2),
        .i_rdata      (mem_rdata),
        .o_be         (w_be),
        .o_wdata      (w_wdata),
        .o_load_value (w_load_value),
        .o_misaligned (w_misaligned),
        .o_illegal    (w_illegal)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (in_valid)   w_state_nxt = w_fault ? RESP : REQ;
            REQ:     if (mem_gnt)    w_state_nxt = r_is_store ? RESP : WAIT_R;
            WAIT_R:  if (mem_rvalid) w_state_nxt = RESP;
            RESP:    if (wb_ready)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_is_store <= 1'b0;
            r_fault    <= 1'b0;
            r_funct3   <= '0;
            r_rd       <= '0;
            r_addr     <= '0;
            r_rs2      <= '0;
            r_next_pc  <= '0;
            r_rd_value <= '0;
        end else begin
            if (w_accept) begin
                r_is_store <= (in_opcode == OPC_STORE);
                r_fault    <= w_fault;
                r_funct3   <= in_funct3;
                r_rd       <= in_rd;
                r_addr     <= w_ea;
                r_rs2      <= in_rs2_value;
                r_next_pc  <= in_pc + 32'd4;
                r_rd_value <= '0;
            end
            if (r_state == WAIT_R && mem_rvalid) begin
                r_rd_value <= w_load_value;
            end
        end
    end

    assign in_ready    = w_idle && !rst;

    assign mem_req     = (r_state == REQ);
    assign mem_we      = mem_req && r_is_store;
    assign mem_addr    = {r_addr[XLEN-1:2], 2'b00};
    assign mem_be      = mem_req ? w_be : 4'h0;
    assign mem_wdata   = mem_we ? w_wdata : '0;

    assign wb_valid    = (r_state == RESP);
    assign wb_we       = wb_valid && !r_fault && !r_is_store && (r_rd != 5'd0);
    assign wb_fault    = wb_valid && r_fault;
    assign wb_rd       = r_rd;
    assign wb_rd_value = r_rd_value;
    assign wb_next_pc  = r_next_pc;

endmodule

`default_nettype wire

// File: tb/tb_dmem_stage.sv
// tb_dmem_stage: directed vectors with a queue-based scoreboard for the
// bus request and the writeback beat of dmem_stage.
`default_nettype none

module tb_dmem_stage;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [6:0]  in_opcode = '0;
    logic [2:0]  in_funct3 = '0;
    logic [31:0] in_rs1_value = '0;
    logic [31:0] in_rs2_value = '0;
    logic [11:0] in_imm = '0;
    logic [4:0]  in_rd = '0;
    logic [31:0] in_pc = '0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = 32'h5A5A5A5A;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_rd_value;
    logic [31:0] wb_next_pc;
    logic        wb_fault;

    dmem_stage #(.XLEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_opcode    (in_opcode),
        .in_funct3    (in_funct3),
        .in_rs1_value (in_rs1_value),
        .in_rs2_value (in_rs2_value),
        .in_imm       (in_imm),
        .in_rd        (in_rd),
        .in_pc        (in_pc),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_be       (mem_be),
        .mem_gnt      (mem_gnt),
        .mem_rvalid   (mem_rvalid),
        .mem_rdata    (mem_rdata),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_we        (wb_we),
        .wb_rd        (wb_rd),
        .wb_rd_value  (wb_rd_value),
        .wb_next_pc   (wb_next_pc),
        .wb_fault     (wb_fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
    } bus_exp_t;

    typedef struct {
        logic        we;
        logic [4:0]  rd;
        logic [31:0] val;
        logic [31:0] npc;
        logic        fault;
        int          cyc;
    } wb_exp_t;

    bus_exp_t bq[$];
    wb_exp_t  wq[$];
    int       n_vec = 0;
    int       n_err = 0;
    bit       done = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // g: cycles of grant delay, rdl: cycles between grant and rvalid beyond
    // the minimum, s: cycles wb_ready is held low once wb_valid appears.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3,
                          input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [11:0] imm, input logic [4:0] rd,
                          input logic [31:0] pc, input logic [31:0] rdata,
                          input int g, input int rdl, input int s,
                          input logic e_fault, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic [31:0] e_val, input logic e_we);
        bus_exp_t b;
        wb_exp_t  w;
        int       k;
        int       c;
        logic     st;
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        c  = cyc;
        st = (op == OPC_STORE);
        in_valid     = 1'b1;
        in_opcode    = op;
        in_funct3    = f3;
        in_rs1_value = rs1;
        in_rs2_value = rs2;
        in_imm       = imm;
        in_rd        = rd;
        in_pc        = pc;
        wb_ready     = (s == 0);
        if (!e_fault) begin
            b.addr = e_addr; b.be = e_be; b.wdata = e_wdata; b.we = st;
            bq.push_back(b);
        end
        w.we = e_we; w.rd = rd; w.val = e_val; w.npc = pc + 32'd4; w.fault = e_fault;
        w.cyc = e_fault ? c + 1 : (st ? c + 2 + g : c + 3 + g + rdl);
        wq.push_back(w);
        step();
        in_valid     = 1'b0;
        in_rs1_value = 32'hFFFF_FFF0;
        in_rs2_value = 32'h0BAD_0BAD;
        if (!e_fault) begin
            repeat (g) step();
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            if (!st) begin
                repeat (rdl) step();
                mem_rdata  = rdata;
                mem_rvalid = 1'b1;
                step();
                mem_rvalid = 1'b0;
                mem_rdata  = 32'h5A5A5A5A;
            end
        end
        repeat (s) step();
        wb_ready = 1'b1;
        step();
    endtask

    initial begin : stimulus
        int k;
        repeat (3) step();
        rst = 1'b0;
        step();
        run_op(OPC_LOAD,  LW,   32'h1000, 32'h0,        12'h004, 5'd5,  32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 32'h1004, 4'hF, 32'h0,        32'hDEADBEEF, 1);
        run_op(OPC_LOAD,  LB,   32'h1000, 32'h0,        12'h003, 5'd6,  32'h104, 32'h80FFFFFF, 0, 0, 0, 0, 32'h1000, 4'h8, 32'h0,        32'hFFFFFF80, 1);
        run_op(OPC_LOAD,  LBU,  32'h1000, 32'h0,        12'h003, 5'd7,  32'h108, 32'h80FFFFFF, 0, 0, 0, 0, 32'h1000, 4'h8, 32'h0,        32'h00000080, 1);
        run_op(OPC_STORE, SH,   32'h2000, 32'h1234ABCD, 12'h002, 5'd0,  32'h10C, 32'h0,        0, 0, 0, 0, 32'h2000, 4'hC, 32'hABCDABCD, 32'h0,        0);
        run_op(OPC_LOAD,  LW,   32'h1000, 32'h0,        12'h002, 5'd4,  32'h110, 32'h0,        0, 0, 0, 1, 32'h0,    4'h0, 32'h0,        32'h0,        0);
        run_op(OPC_LOAD,  3'd3, 32'h1000, 32'h0,        12'h000, 5'd4,  32'h114, 32'h0,        0, 0, 0, 1, 32'h0,    4'h0, 32'h0,        32'h0,        0);
        run_op(OPC_LOAD,  LH,   32'h3000, 32'h0,        12'hFFE, 5'd10, 32'h118, 32'h80011234, 3, 0, 2, 0, 32'h2FFC, 4'hC, 32'h0,        32'hFFFF8001, 1);
        run_op(OPC_STORE, SB,   32'h0010, 32'h000000A5, 12'h001, 5'd0,  32'h11C, 32'h0,        1, 0, 0, 0, 32'h0010, 4'h2, 32'hA5A5A5A5, 32'h0,        0);
        run_op(OPC_STORE, SW,   32'h4000, 32'hCAFEF00D, 12'h7FC, 5'd0,  32'h120, 32'h0,        0, 0, 1, 0, 32'h47FC, 4'hF, 32'hCAFEF00D, 32'h0,        0);
        run_op(OPC_LOAD,  LHU,  32'h0000, 32'h0,        12'h002, 5'd0,  32'h124, 32'hF00D0000, 0, 2, 0, 0, 32'h0000, 4'hC, 32'h0,        32'h0000F00D, 0);
        run_op(OPC_STORE, 3'd3, 32'h2000, 32'h1,        12'h000, 5'd0,  32'h128, 32'h0,        0, 0, 0, 1, 32'h0,    4'h0, 32'h0,        32'h0,        0);
        run_op(OPC_STORE, SH,   32'h2000, 32'h1,        12'h001, 5'd0,  32'h12C, 32'h0,        0, 0, 0, 1, 32'h0,    4'h0, 32'h0,        32'h0,        0);
        run_op(OPC_LOAD,  LB,   32'h1005, 32'h0,        12'hFFF, 5'd31, 32'h130, 32'h0000007F, 0, 1, 0, 0, 32'h1004, 4'h1, 32'h0,        32'h0000007F, 1);

        // Abandon a load in WAIT_R with reset; the late rvalid must vanish.
        k = 0;
        while (!in_ready && k < 50) begin
            step();
            k++;
        end
        begin
            bus_exp_t b;
            b.addr = 32'h1004; b.be = 4'hF; b.wdata = 32'h0; b.we = 1'b0;
            bq.push_back(b);
        end
        in_valid = 1'b1; in_opcode = OPC_LOAD; in_funct3 = LW;
        in_rs1_value = 32'h1000; in_imm = 12'h004; in_rd = 5'd9; in_pc = 32'h200;
        step();
        in_valid = 1'b0;
        mem_gnt  = 1'b1;
        step();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        step();
        rst        = 1'b0;
        mem_rdata  = 32'h12345678;
        mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        repeat (5) step();
        done = 1'b1;
    end

    initial begin : monitor
        logic        prev_rst;
        logic        prev_req_wait;
        logic        prev_wb_stall;
        logic        wb_first_done;
        logic [31:0] p_addr;
        logic [31:0] p_wdata;
        logic [3:0]  p_be;
        logic        p_we;
        logic        p_wb_we;
        logic        p_wb_fault;
        logic [4:0]  p_wb_rd;
        logic [31:0] p_wb_val;
        logic [31:0] p_wb_npc;
        bus_exp_t    b;
        wb_exp_t     w;
        prev_rst = 1'b0; prev_req_wait = 1'b0; prev_wb_stall = 1'b0; wb_first_done = 1'b0;
        p_addr = '0; p_wdata = '0; p_be = '0; p_we = 1'b0;
        p_wb_we = 1'b0; p_wb_fault = 1'b0; p_wb_rd = '0; p_wb_val = '0; p_wb_npc = '0;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            if (rst) chk("in_ready_during_rst", {31'd0, in_ready}, 32'd0);
            if (prev_rst && !rst) chk("in_ready_after_rst", {31'd0, in_ready}, 32'd1);
            if (prev_rst) begin
                chk("rst_ctrl", {27'd0, mem_req, mem_we, wb_valid, wb_we, wb_fault}, 32'd0);
                chk("rst_mem_addr", mem_addr, 32'd0);
                chk("rst_mem_wdata", mem_wdata, 32'd0);
                chk("rst_mem_be", {28'd0, mem_be}, 32'd0);
                chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
                chk("rst_wb_rd_value", wb_rd_value, 32'd0);
                chk("rst_wb_next_pc", wb_next_pc, 32'd0);
            end

            if (prev_req_wait && !prev_rst) begin
                chk("req_held", {31'd0, mem_req}, 32'd1);
                chk("req_addr_stable", mem_addr, p_addr);
                chk("req_be_stable", {28'd0, mem_be}, {28'd0, p_be});
                chk("req_wdata_stable", mem_wdata, p_wdata);
                chk("req_we_stable", {31'd0, mem_we}, {31'd0, p_we});
            end
            if (mem_req) begin
                chk("in_ready_in_req", {31'd0, in_ready}, 32'd0);
                if (bq.size() == 0) begin
                    chk("unexpected_mem_req", 32'd1, 32'd0);
                end else if (mem_gnt) begin
                    b = bq.pop_front();
                    chk("mem_addr", mem_addr, b.addr);
                    chk("mem_be", {28'd0, mem_be}, {28'd0, b.be});
                    chk("mem_we", {31'd0, mem_we}, {31'd0, b.we});
                    if (b.we) chk("mem_wdata", mem_wdata, b.wdata);
                end
            end
            prev_req_wait = mem_req && !mem_gnt;
            p_addr = mem_addr; p_be = mem_be; p_wdata = mem_wdata; p_we = mem_we;

            if (prev_wb_stall && !prev_rst) begin
                chk("wb_valid_held", {31'd0, wb_valid}, 32'd1);
                chk("wb_we_stable", {31'd0, wb_we}, {31'd0, p_wb_we});
                chk("wb_fault_stable", {31'd0, wb_fault}, {31'd0, p_wb_fault});
                chk("wb_rd_stable", {27'd0, wb_rd}, {27'd0, p_wb_rd});
                chk("wb_val_stable", wb_rd_value, p_wb_val);
                chk("wb_npc_stable", wb_next_pc, p_wb_npc);
            end
            if (wb_valid) begin
                chk("in_ready_in_resp", {31'd0, in_ready}, 32'd0);
                if (wq.size() == 0) begin
                    chk("unexpected_wb_valid", 32'd1, 32'd0);
                end else begin
                    if (!wb_first_done) begin
                        chk("wb_latency", cyc, wq[0].cyc);
                        wb_first_done = 1'b1;
                    end
                    if (wb_ready) begin
                        w = wq.pop_front();
                        wb_first_done = 1'b0;
                        chk("wb_we", {31'd0, wb_we}, {31'd0, w.we});
                        chk("wb_fault", {31'd0, wb_fault}, {31'd0, w.fault});
                        chk("wb_rd", {27'd0, wb_rd}, {27'd0, w.rd});
                        chk("wb_rd_value", wb_rd_value, w.val);
                        chk("wb_next_pc", wb_next_pc, w.npc);
                    end
                end
            end
            prev_wb_stall = wb_valid && !wb_ready;
            p_wb_we = wb_we; p_wb_fault = wb_fault; p_wb_rd = wb_rd;
            p_wb_val = wb_rd_value; p_wb_npc = wb_next_pc;
            prev_rst = rst;
        end
        if (!done) chk("timeout", 32'd1, 32'd0);
        chk("bus_queue_drained", bq.size(), 32'd0);
        chk("wb_queue_drained", wq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/dmem_stage.md
# dmem_stage

Data-memory stage of the RV32I pipeline, parallel to the exec stage on the decode output and feeding the writeback stage. It accepts one load or store at a time and computes the effective address. It runs a request/grant/response transaction on the data bus, aligns and extends load data, and hands a single result beat to writeback.

## Interface
Parameters:
- XLEN, 32, data/address width
- (none other)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decode presents a memory op
- in_ready  out  1  stage accepts op (IDLE only)
- in_opcode  in  7  LOAD (0000011) or STORE (0100011)
- in_funct3  in  3  width/sign select
- in_rs1_value  in  XLEN  base register value
- in_rs2_value  in  XLEN  store data
- in_imm  in  12  I/S immediate, sign-extended here
- in_rd  in  5  load destination
- in_pc  in  XLEN  instruction PC
- mem_req  out  1  bus request, held until grant
- mem_we  out  1  1 = store
- mem_addr  out  XLEN  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  XLEN  lane-shifted store data
- mem_be  out  4  byte enables
- mem_gnt  in  1  bus accepted request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  XLEN  read data word
- wb_valid  out  1  result beat valid
- wb_ready  in  1  writeback accepts beat
- wb_we  out  1  write wb_rd_value to wb_rd
- wb_rd  out  5  destination register
- wb_rd_value  out  XLEN  extended load data
- wb_next_pc  out  XLEN  in_pc + 4
- wb_fault  out  1  misaligned or illegal funct3; no bus access made

## Operation
- FSM states: IDLE, REQ, WAIT_R, RESP.
- IDLE: in_ready=1. On in_valid, latch all inputs and compute addr = rs1 + sext(imm) (mod 2^32).
  - If faulted, go to RESP with wb_fault=1 and wb_we=0.
  - Otherwise go to REQ.
- Fault conditions:
  - Misaligned: LH/LHU/SH with addr[0]≠0; LW/SW with addr[1:0]≠0.
  - Illegal: load funct3 ∈ {3,6,7}; store funct3 ≥ 3.
- REQ: mem_req=1. mem_we, mem_addr, mem_be and mem_wdata are stable until mem_gnt.
  - On gnt, a store goes to RESP; a load goes to WAIT_R.
- Store lanes:
  - SB: be=1<<addr[1:0], wdata={4{rs2[7:0]}}.
  - SH: be=3<<addr[1:0], wdata={2{rs2[15:0]}}.
  - SW: be=4'hF, wdata=rs2.
- WAIT_R: on mem_rvalid, select the byte/half at addr[1:0] and extend it. LB/LH sign-extend, LBU/LHU zero-extend, LW passes the word. Register the result, then go to RESP.
- RESP: wb_valid=1 and all wb_* outputs are held stable until wb_ready, then go to IDLE.
  - wb_we=1 only for a non-faulting load with rd≠0.
  - Stores report wb_we=0 and wb_rd_value=0.
- wb_next_pc = latched pc + 4 for every op.

## Timing
- Reset: state=IDLE. mem_req, mem_we, wb_valid, wb_we and wb_fault are 0. mem_addr, mem_wdata, mem_be, wb_rd, wb_rd_value and wb_next_pc are 0. in_ready is 0 while rst is high and 1 on the first cycle after.
- Accept in cycle 0 gives mem_req in cycle 1.
- Store with immediate grant: wb_valid in cycle 2.
- Load with gnt in cycle 1 and rvalid in cycle 2: wb_valid in cycle 3.
- Fault: wb_valid in cycle 1.
- mem_rvalid is honoured no earlier than the cycle after mem_gnt. mem_rvalid seen in IDLE, REQ or RESP is ignored.
- wb_ready low stalls in RESP indefinitely. in_ready stays 0 until the cycle after the wb handshake, so there is no back-to-back overlap (one op in flight).
- Reset mid-transaction returns to IDLE the next cycle and drops the op. A late rvalid from the abandoned load is ignored.

## Structure
- Package defs adds:
  - LOAD/STORE opcode constants.
  - funct3 constants LB, LH, LW, LBU, LHU, SB, SH, SW.
  - typedef enum dmem_state_t {IDLE, REQ, WAIT_R, RESP}.
- Sub-module dmem_lane_align (combinational): inputs funct3, addr[1:0], rs2, rdata; outputs be, wdata, load value, misaligned, illegal. The FSM and registers stay in dmem_stage.

## Test plan
- LW: rs1=0x1000, imm=0x004, rdata=0xDEADBEEF, gnt in cycle 1, rvalid in cycle 2 -> mem_addr=0x1004, be=F, cycle-3 wb_valid, wb_rd_value=0xDEADBEEF, wb_we=1.
- LB/LBU at addr 0x1003, rdata=0x80FFFFFF -> LB gives 0xFFFFFF80; LBU gives 0x00000080.
- SH: rs1=0x2000, imm=0x002, rs2=0x1234ABCD -> mem_be=4'b1100, mem_wdata=0xABCDABCD, mem_we=1, wb_we=0.
- LW at 0x1002 -> no mem_req, wb_valid in cycle 1 with wb_fault=1, wb_we=0. Load funct3=3 -> same result.
- mem_gnt held low for 3 cycles with wb_ready held low for 2 cycles -> mem_req/addr stable throughout; wb_* outputs stable and in_ready=0 until the handshake.
- rst asserted in WAIT_R, rvalid pulsed afterwards -> IDLE, wb_valid stays 0, in_ready=1 after reset.
